// File: rtl/i2c_line_conditioner_if.sv
// ---------------------------------------------------------------------------
// i2c_line_conditioner_if
// Bundle between the raw open-drain I2C pins / protocol cores and the line
// conditioner.
//   slave  modport : the conditioner's view (pins and drive requests in,
//                    filtered lines, pin drive and event pulses out)
//   master modport : the driving side (pins, cores) feeding the conditioner
// Signals:
//   SDA_in, SCL_in          raw pin values
//   SDA_out_master/_slave   SDA drive requests, 0 = pull low, 1 = release
//   SCL_out_master/_slave   SCL drive requests (slave side = clock stretch)
//   master_active           master owns a transaction (arbitration check on)
//   timeout_cycles          SCL-low limit (used only in the timeout build)
//   SDA_out, SCL_out        registered pin drive, 0 = pull low
//   SDA_sync, SCL_sync      synchronised and glitch-filtered lines
//   start_det, stop_det     1-cycle START / STOP pulses
//   line_busy               bus held between START and STOP
//   arb_lost                1-cycle pulse, master lost arbitration
//   scl_timeout             1-cycle pulse, SCL held low too long
// ---------------------------------------------------------------------------
interface i2c_line_conditioner_if #(
    parameter int TIMEOUT_W = 16
);
    logic                 SDA_in;
    logic                 SCL_in;
    logic                 SDA_out_master;
    logic                 SDA_out_slave;
    logic                 SCL_out_master;
    logic                 SCL_out_slave;
    logic                 master_active;
    logic [TIMEOUT_W-1:0] timeout_cycles;
    logic                 SDA_out;
    logic                 SCL_out;
    logic                 SDA_sync;
    logic                 SCL_sync;
    logic                 start_det;
    logic                 stop_det;
    logic                 line_busy;
    logic                 arb_lost;
    logic                 scl_timeout;

    modport slave (
        input  SDA_in, SCL_in, SDA_out_master, SDA_out_slave,
               SCL_out_master, SCL_out_slave, master_active, timeout_cycles,
        output SDA_out, SCL_out, SDA_sync, SCL_sync, start_det, stop_det,
               line_busy, arb_lost, scl_timeout
    );

    modport master (
        output SDA_in, SCL_in, SDA_out_master, SDA_out_slave,
               SCL_out_master, SCL_out_slave, master_active, timeout_cycles,
        input  SDA_out, SCL_out, SDA_sync, SCL_sync, start_det, stop_det,
               line_busy, arb_lost, scl_timeout
    );
endinterface

// File: rtl/i2c_line_conditioner.sv
// ---------------------------------------------------------------------------
// i2c_line_conditioner
// Front end between the raw open-drain I2C pins and the master/slave cores:
//   - synchronises and glitch-filters SDA/SCL (SDA_sync/SCL_sync)
//   - detects START / STOP and tracks line_busy (IDLE/BUSY FSM)
//   - wire-ANDs master and slave drive requests into a registered pin drive
//   - flags lost arbitration
//   - optional SCL-stuck-low timeout, built only when the macro
//     I2C_SCL_TIMEOUT_EN is defined; otherwise scl_timeout is tied low and
//     timeout_cycles is ignored
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   bus    i2c_line_conditioner_if.slave (pins, drive requests, outputs)
// Parameters:
//   SYNC_STAGES  metastability flops per line (>= 2)
//   FILTER_LEN   consecutive disagreeing samples before a filtered line flips
//   TIMEOUT_W    width of the SCL-low counter and of timeout_cycles
// ---------------------------------------------------------------------------
module i2c_line_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                         clk,
    input  logic                         n_rst,
    i2c_line_conditioner_if.slave        bus
);

    localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
    // The counter flips the line on the FILTER_LEN-th mismatch, i.e. while
    // it still holds FILTER_LEN-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Line index 0 = SDA, 1 = SCL.
    logic [1:0] raw_s;
    logic [1:0] filt_q_s;   // current filtered value (SDA_sync/SCL_sync)
    logic [1:0] filt_d_s;   // filtered value after the coming edge

    assign raw_s = {bus.SCL_in, bus.SDA_in};

    generate
        for (genvar l = 0; l < 2; l++) begin : g_line
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   filt_q;
            logic                   filt_d;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       cnt_d;

            // Metastability chain, shifted towards the MSB.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    sync_q <= {SYNC_STAGES{1'b1}};
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], raw_s[l]};
                end
            end

            // Glitch filter: count consecutive disagreements, flip on the last one.
            always_comb begin
                filt_d = filt_q;
                cnt_d  = {CNT_W{1'b0}};
                if (sync_q[SYNC_STAGES-1] != filt_q) begin
                    if (cnt_q == CNT_LAST) begin
                        filt_d = ~filt_q;
                        cnt_d  = {CNT_W{1'b0}};
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = {CNT_W{1'b0}};
                end
            end

            // Filter state registers.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    filt_q <= 1'b1;
                    cnt_q  <= {CNT_W{1'b0}};
                end else begin
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign filt_q_s[l] = filt_q;
            assign filt_d_s[l] = filt_d;
        end
    endgenerate

    // Conditions are evaluated on the value the filtered lines take at the
    // coming edge against their present value (the previous-cycle copy), so
    // the registered pulses line up with the SDA_sync/SCL_sync change.
    logic sda_new_s;
    logic scl_new_s;
    logic sda_prev_s;
    logic scl_prev_s;
    logic start_s;
    logic stop_s;
    logic scl_rise_s;
    logic arb_s;
    logic to_hit_s;

    state_t state_q;
    logic   sda_out_q;
    logic   scl_out_q;
    logic   start_det_q;
    logic   stop_det_q;
    logic   line_busy_q;
    logic   arb_lost_q;
    logic   scl_timeout_q;

    assign sda_new_s  = filt_d_s[0];
    assign scl_new_s  = filt_d_s[1];
    assign sda_prev_s = filt_q_s[0];
    assign scl_prev_s = filt_q_s[1];

    // SDA only counts as a condition while SCL is high on both samples,
    // which makes START and STOP mutually exclusive.
    assign start_s    = scl_new_s & scl_prev_s &  sda_prev_s & ~sda_new_s;
    assign stop_s     = scl_new_s & scl_prev_s & ~sda_prev_s &  sda_new_s;
    assign scl_rise_s = ~scl_prev_s & scl_new_s;

    // We released SDA but the bus reads low at the SCL rise: someone else won.
    assign arb_s = scl_rise_s & (state_q == ST_BUSY) & bus.master_active &
                   sda_out_q & ~sda_new_s;

`ifdef I2C_SCL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_q;
    logic [TIMEOUT_W-1:0] to_cnt_d;
    logic [TIMEOUT_W-1:0] to_inc_s;

    assign to_inc_s = to_cnt_q + TIMEOUT_W'(1);

    // SCL-low counter; the hit fires as the count reaches the limit.
    always_comb begin
        to_cnt_d = {TIMEOUT_W{1'b0}};
        to_hit_s = 1'b0;
        if ((state_q == ST_BUSY) && !scl_prev_s) begin
            if ((bus.timeout_cycles != {TIMEOUT_W{1'b0}}) &&
                (to_inc_s == bus.timeout_cycles)) begin
                to_hit_s = 1'b1;
                to_cnt_d = {TIMEOUT_W{1'b0}};
            end else begin
                to_cnt_d = to_inc_s;
            end
        end else begin
            to_cnt_d = {TIMEOUT_W{1'b0}};
        end
    end

    // SCL-low counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt_q <= {TIMEOUT_W{1'b0}};
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout_s;

    assign to_hit_s         = 1'b0;
    assign unused_timeout_s = ^bus.timeout_cycles;
`endif

    // Bus-state FSM with registered condition and arbitration pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            line_busy_q   <= 1'b0;
            start_det_q   <= 1'b0;
            stop_det_q    <= 1'b0;
            arb_lost_q    <= 1'b0;
            scl_timeout_q <= 1'b0;
        end else begin
            start_det_q   <= start_s;
            stop_det_q    <= stop_s;
            arb_lost_q    <= arb_s;
            scl_timeout_q <= to_hit_s;
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q     <= ST_BUSY;
                        line_busy_q <= 1'b1;
                    end else begin
                        state_q     <= ST_IDLE;
                        line_busy_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (stop_s || to_hit_s) begin
                        state_q     <= ST_IDLE;
                        line_busy_q <= 1'b0;
                    end else begin
                        state_q     <= ST_BUSY;
                        line_busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    line_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Open-drain wire-AND of the drive requests, registered once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_out_q <= 1'b1;
            scl_out_q <= 1'b1;
        end else begin
            sda_out_q <= bus.SDA_out_master & bus.SDA_out_slave;
            scl_out_q <= bus.SCL_out_master & bus.SCL_out_slave;
        end
    end

    assign bus.SDA_out     = sda_out_q;
    assign bus.SCL_out     = scl_out_q;
    assign bus.SDA_sync    = filt_q_s[0];
    assign bus.SCL_sync    = filt_q_s[1];
    assign bus.start_det   = start_det_q;
    assign bus.stop_det    = stop_det_q;
    assign bus.line_busy   = line_busy_q;
    assign bus.arb_lost    = arb_lost_q;
    assign bus.scl_timeout = scl_timeout_q;

endmodule
